if_id_queue: RTL and testbench

- Receiving end of the fetch-stage output (PC, instruction): a DEPTH-entry instruction queue between fetch and decode.
- Decouples decode stalls from fetch, and discards all buffered wrong-path instructions when a branch is taken (flush).
- Presents the oldest buffered PC/instruction pair to decode with a valid/ready handshake.
- Gives fetch back-pressure through in_ready.

---
 rtl/if_id_queue.sv | 81 ++++++++
 tb/tb_if_id_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO of (PC, instruction) pairs
// with valid/ready handshake on both sides and a single-cycle flush for taken branches.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_PC,
  input  logic [WIDTH-1:0] in_instruction,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_PC,
  output logic [WIDTH-1:0] out_instruction,
  input  logic             out_ready,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Status depends only on registered count, so in_ready never sees out_ready.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign out_PC          = out_valid ? pc_mem[rd_ptr_q]    : '0;
  assign out_instruction = out_valid ? instr_mem[rd_ptr_q] : '0;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared by reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem[wr_ptr_q]    <= in_PC;
      instr_mem[wr_ptr_q] <= in_instruction;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue model predicts every cycle's outputs and the
// entry each pop must deliver.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_PC;
  logic [WIDTH-1:0] in_instruction;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_PC;
  logic [WIDTH-1:0] out_instruction;
  logic             out_ready;
  logic [CntW-1:0]  count;

  ent_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  logic [WIDTH-1:0] fill_instr [4] = '{32'h20010005, 32'h20020006, 32'h00221820, 32'hAC030000};

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_PC          (in_PC),
    .in_instruction (in_instruction),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_PC         (out_PC),
    .out_instruction(out_instruction),
    .out_ready      (out_ready),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [WIDTH-1:0] got,
                           input logic [WIDTH-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs are already set (clock low); check outputs, advance model, then one clock.
  task automatic tick();
    int   n;
    bit   push, pop;
    ent_t e;
    n = sb.size();
    if (chk_en) begin
      check_val("count", WIDTH'(count), WIDTH'(n));
      check_val("in_ready", WIDTH'(in_ready), WIDTH'(n != DEPTH));
      check_val("out_valid", WIDTH'(out_valid), WIDTH'(n != 0));
      check_val("out_pc", out_PC, (n != 0) ? sb[0].pc : '0);
      check_val("out_instr", out_instruction, (n != 0) ? sb[0].instr : '0);
    end
    push = in_valid && (n != DEPTH) && !flush;
    pop  = (n != 0) && out_ready && !flush;
    if (!rst || flush) begin
      sb.delete();
    end else begin
      if (pop) begin
        e = sb.pop_front();
        if (chk_en) check_val("pop_pc", out_PC, e.pc);
      end
      if (push) sb.push_back('{pc: in_PC, instr: in_instruction});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins,
                       input logic rdy);
    in_valid       = v;
    in_PC          = pc;
    in_instruction = ins;
    out_ready      = rdy;
  endtask

  function automatic logic [WIDTH-1:0] mk_instr(input logic [WIDTH-1:0] pc);
    return 32'hC0DE0000 ^ (pc * 32'd3);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // Fill with decode stalled, attempt a fifth push, then drain.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'(4 * i), fill_instr[i], 1'b0);
      tick();
    end
    drive(1'b1, 32'd16, 32'hDEADBEEF, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) tick();

    // Steady push+pop at count 2 across pointer wrap.
    drive(1'b1, 32'h10, mk_instr(32'h10), 1'b0);
    tick();
    drive(1'b1, 32'h14, mk_instr(32'h14), 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h18 + WIDTH'(4 * i), mk_instr(32'h18 + WIDTH'(4 * i)), 1'b1);
      tick();
    end

    // Third entry, then flush with a push and pop offered in the same cycle.
    drive(1'b1, 32'h3C, mk_instr(32'h3C), 1'b0);
    tick();
    flush = 1'b1;
    drive(1'b1, 32'h40, mk_instr(32'h40), 1'b1);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h80, mk_instr(32'h80), 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();

    // Full plus pop: no pass-through, push lands the following cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hC0 + WIDTH'(4 * i), mk_instr(32'hC0 + WIDTH'(4 * i)), 1'b0);
      tick();
    end
    drive(1'b1, 32'h100, mk_instr(32'h100), 1'b1);
    tick();
    tick();
    drive(1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 5; i++) tick();

    // Reset mid-operation with push and pop offered.
    drive(1'b1, 32'h200, mk_instr(32'h200), 1'b0);
    tick();
    drive(1'b1, 32'h204, mk_instr(32'h204), 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h208, mk_instr(32'h208), 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
